system_memio: RTL and testbench

SYSTEM_MEMIO -- requirements
Module: system_memio

---
 rtl/system_memio.sv | 164 ++++++++++++++++
 tb/tb_system_memio.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/system_memio.sv
// system_memio: wait-stated memory-mapped RAM, per-channel byte output FIFOs and a status/error register.
module system_memio #(
  parameter int    MEM_WORDS   = 4096,
  parameter int    WAIT_STATES = 1,
  parameter int    NUM_CH      = 2,
  parameter int    FIFO_DEPTH  = 4,
  parameter string INIT_FILE   = "firmware.hex"
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                mem_valid,
  input  logic                mem_instr,
  output logic                mem_ready,
  input  logic [31:0]         mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_rdata,
  output logic [8*NUM_CH-1:0] out_byte,
  output logic [NUM_CH-1:0]   out_valid,
  input  logic [NUM_CH-1:0]   out_ready,
  output logic                bus_error
);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] RAM_TOP = 32'(4 * MEM_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, STALL, RESP} state_t;

  state_t            state_q, state_d;
  logic [2:0]        wcnt_q, wcnt_d;
  logic [31:0]       addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              live_q, live_d, be_q, be_d;
  logic              accept, go, push, ch_full, be_set, be_clr;
  logic              req_ram, req_ch, req_stat, req_err, req_wr;
  logic [31:0]       req_addr, req_wdata, status;
  logic [3:0]        req_wstrb;
  logic [2:0]        req_ch_idx;
  logic [IW-1:0]     ram_idx;
  logic [NUM_CH-1:0] full, empty;
  logic [7:0]        full_pad;
  logic [31:0]       ram [MEM_WORDS];
  logic [31:0]       ram_rd_q;
  logic              unused_instr;

  assign unused_instr = mem_instr;

  always_comb begin
    live_d     = 1'b1;
    accept     = live_q && state_q == IDLE && mem_valid;
    // In IDLE the live bus fields are decoded so a zero-wait access can complete on the accept edge.
    req_addr   = state_q == IDLE ? mem_addr : addr_q;
    req_wdata  = state_q == IDLE ? mem_wdata : wdata_q;
    req_wstrb  = state_q == IDLE ? mem_wstrb : wstrb_q;
    req_wr     = |req_wstrb;
    req_ch_idx = req_addr[4:2];
    ram_idx    = req_addr[IW+1:2];
    req_ram    = req_addr < RAM_TOP;
    req_ch     = req_addr[31:5] == 27'h080_0000 && req_addr[1:0] == 2'b00 && 32'(req_ch_idx) < NUM_CH;
    req_stat   = req_addr == 32'h1000_0100;
    req_err    = !(req_ram || req_ch || req_stat);
    full_pad   = '0;
    full_pad[NUM_CH-1:0] = full;
    ch_full    = req_ch && req_wr && full_pad[req_ch_idx];
    addr_d     = accept ? mem_addr : addr_q;
    wdata_d    = accept ? mem_wdata : wdata_q;
    wstrb_d    = accept ? mem_wstrb : wstrb_q;
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (accept) begin
          if (WAIT_STATES != 0) state_d = WAIT;
          else if (ch_full) state_d = STALL;
          else state_d = RESP;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q + 3'd1;
        if (wcnt_q == 3'(WAIT_STATES - 1)) begin
          if (ch_full) state_d = STALL;
          else state_d = RESP;
        end
      end
      STALL: if (!ch_full) state_d = RESP;
      default: state_d = IDLE;
    endcase
    go     = state_d == RESP && state_q != RESP;
    push   = go && req_ch && req_wr;
    be_set = go && req_err;
    be_clr = go && req_stat && req_wstrb[3] && req_wdata[31];
    be_d   = be_set ? 1'b1 : be_clr ? 1'b0 : be_q;
    status = '0;
    status[31] = be_q;
    for (int i = 0; i < NUM_CH; i++) begin
      status[i]   = full[i];
      status[8+i] = empty[i];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      live_q  <= 1'b0;
      be_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      live_q  <= live_d;
      be_q    <= be_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (go && req_ram && req_wstrb[b]) ram[ram_idx][8*b +: 8] <= req_wdata[8*b +: 8];
    ram_rd_q <= ram[ram_idx];
  end

  assign mem_ready = state_q == RESP;
  assign mem_rdata = (state_q == RESP && !req_wr) ? (req_ram ? ram_rd_q : req_stat ? status : '0) : '0;
  assign bus_error = be_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [7:0]    fifo [FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_c, pop_c;
    always_comb begin
      push_c = push && req_ch_idx == 3'(c);
      pop_c  = cnt_q != '0 && out_ready[c];
      wp_d   = wp_q + AW'(push_c);
      rp_d   = rp_q + AW'(pop_c);
      cnt_d  = cnt_q + CW'(push_c) - CW'(pop_c);
    end
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp_q  <= '0;
        rp_q  <= '0;
        cnt_q <= '0;
      end else begin
        wp_q  <= wp_d;
        rp_q  <= rp_d;
        cnt_q <= cnt_d;
      end
    end
    always_ff @(posedge clk) begin
      if (push_c) fifo[wp_q] <= req_wdata[7:0];
    end
    assign full[c]             = cnt_q == CW'(FIFO_DEPTH);
    assign empty[c]            = cnt_q == '0;
    assign out_valid[c]        = !empty[c];
    assign out_byte[8*c +: 8]  = empty[c] ? 8'h00 : fifo[rp_q];
  end
endmodule

// File: tb/tb_system_memio.sv
// tb_system_memio: scoreboard bench for system_memio with two wait states, two channels, depth-4 FIFOs.
module tb_system_memio;
  logic        clk = 1'b0, reset = 1'b1;
  logic        mem_valid = 1'b0, mem_instr = 1'b0, mem_ready, bus_error;
  logic [31:0] mem_addr = '0, mem_wdata = '0, mem_rdata;
  logic [3:0]  mem_wstrb = '0;
  logic [15:0] out_byte;
  logic [1:0]  out_valid, out_ready = '0;
  int          checks = 0, errors = 0, cyc = 0, first_pop = -1, ready_cyc = 0, lat5 = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  bq0[$], bq1[$];
  logic [31:0] ram_m [int];

  system_memio #(.MEM_WORDS(256), .WAIT_STATES(2), .NUM_CH(2), .FIFO_DEPTH(4), .INIT_FILE("")) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .out_byte(out_byte), .out_valid(out_valid), .out_ready(out_ready), .bus_error(bus_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid[0] && out_ready[0]) begin
        if (first_pop < 0) first_pop = cyc;
        if (bq0.size() == 0) chk("ch0_extra_pop", 1, 0);
        else chk("ch0_byte", {24'h0, out_byte[7:0]}, {24'h0, bq0.pop_front()});
      end
      if (out_valid[1] && out_ready[1]) begin
        if (bq1.size() == 0) chk("ch1_extra_pop", 1, 0);
        else chk("ch1_byte", {24'h0, out_byte[15:8]}, {24'h0, bq1.pop_front()});
      end
    end
  end

  task automatic req(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] e, output int lat);
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    exp_q.push_back(e);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!mem_ready && lat < 60);
    if (!mem_ready) chk({tag, "_timeout"}, 0, 1);
    chk(tag, mem_rdata, exp_q.pop_front());
    ready_cyc = cyc;
    mem_valid = 1'b0; mem_wstrb = '0;
  endtask

  task automatic acc(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] e);
    int lat;
    req(tag, a, d, s, e, lat);
    chk({tag, "_lat"}, lat, 3);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    w = ram_m.exists(int'(a >> 2)) ? ram_m[int'(a >> 2)] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) w[8*b +: 8] = d[8*b +: 8];
    ram_m[int'(a >> 2)] = w;
    acc("ram_wr", a, d, s, 32'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    acc("ram_rd", a, 32'h0, 4'h0, ram_m[int'(a >> 2)]);
  endtask

  task automatic wr_ch(input int c, input logic [7:0] b);
    if (c == 0) bq0.push_back(b); else bq1.push_back(b);
    acc("ch_wr", 32'h1000_0000 + 32'(4 * c), {24'hFFFFFF, b}, 4'h1, 32'h0);
  endtask

  task automatic set_rdy(input logic [1:0] v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #3;
    chk("rst_ready", {31'h0, mem_ready}, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_valid", {30'h0, out_valid}, 0);
    chk("rst_byte", {16'h0, out_byte}, 0);
    chk("rst_berr", {31'h0, bus_error}, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    wr(32'h10, 32'h1122_3344, 4'hF);
    wr(32'h10, 32'hAABB_CCDD, 4'b0101);
    acc("lane_rd", 32'h10, 32'h0, 4'h0, 32'h11BB_33DD);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h40 + 32'(8 * i);
      wr(a, $urandom, 4'hF);
      wr(a | 32'h1, $urandom, 4'($urandom_range(1, 15)));
      rd(a | 32'(i & 3));
    end
    wr(32'h3FC, 32'hDEAD_BEEF, 4'hF);
    rd(32'h3FC);
    wr(32'h0, 32'hCAFE_F00D, 4'hF);
    @(negedge clk);
    chk("idle_rdata", mem_rdata, 0);
    chk("idle_ready", {31'h0, mem_ready}, 0);

    acc("err_rd", 32'h2000_0000, 32'h0, 4'h0, 32'h0);
    chk("berr_set", {31'h0, bus_error}, 1);
    acc("stat_err", 32'h1000_0100, 32'h0, 4'h0, 32'h8000_0300);
    acc("stat_noclr", 32'h1000_0100, 32'h0, 4'b1000, 32'h0);
    chk("berr_kept", {31'h0, bus_error}, 1);
    acc("stat_clr", 32'h1000_0100, 32'h8000_0000, 4'b1000, 32'h0);
    chk("berr_clr", {31'h0, bus_error}, 0);
    acc("err_wr", 32'h400, 32'h1234_5678, 4'hF, 32'h0);
    chk("berr_wr", {31'h0, bus_error}, 1);
    rd(32'h0);
    acc("stat_clr2", 32'h1000_0100, 32'h8000_0000, 4'b1000, 32'h0);

    wr_ch(1, 8'h61);
    wr_ch(1, 8'h62);
    acc("stat_ch1", 32'h1000_0100, 32'h0, 4'h0, 32'h0000_0100);
    acc("ch1_rd", 32'h1000_0004, 32'h0, 4'h0, 32'h0);
    set_rdy(2'b10);
    repeat (4) @(negedge clk);
    chk("ch1_drained", bq1.size(), 0);
    chk("ch1_empty", {30'h0, out_valid}, 0);
    set_rdy(2'b00);

    for (int i = 0; i < 4; i++) wr_ch(0, 8'h41 + 8'(i));
    acc("stat_full", 32'h1000_0100, 32'h0, 4'h0, 32'h0000_0201);
    bq0.push_back(8'h45);
    first_pop = -1;
    fork
      req("ch0_w5", 32'h1000_0000, 32'h45, 4'h1, 32'h0, lat5);
      begin
        repeat (8) @(negedge clk);
        chk("stall_ready", {31'h0, mem_ready}, 0);
        chk("stall_head", {24'h0, out_byte[7:0]}, 32'h41);
        set_rdy(2'b01);
      end
    join
    chk("stall_lat", {31'h0, lat5 > 3}, 1);
    chk("ready_after_pop", ready_cyc - first_pop, 2);
    repeat (6) @(negedge clk);
    chk("ch0_drained", bq0.size(), 0);
    chk("ch0_empty", {30'h0, out_valid}, 0);
    set_rdy(2'b00);

    for (int i = 0; i < 4; i++) wr_ch(0, 8'h70 + 8'(i));
    @(negedge clk);
    mem_valid = 1'b1; mem_addr = 32'h1000_0000; mem_wdata = 32'h99; mem_wstrb = 4'h1;
    repeat (6) begin
      @(negedge clk);
      chk("rst_stall_ready", {31'h0, mem_ready}, 0);
    end
    #2 reset = 1'b1;
    mem_valid = 1'b0; mem_wstrb = '0;
    #1;
    chk("arst_ready", {31'h0, mem_ready}, 0);
    chk("arst_valid", {30'h0, out_valid}, 0);
    chk("arst_byte", {16'h0, out_byte}, 0);
    chk("arst_rdata", mem_rdata, 0);
    bq0.delete();
    @(negedge clk);
    reset = 1'b0;
    set_rdy(2'b01);
    repeat (3) @(negedge clk);
    chk("post_rst_valid", {30'h0, out_valid}, 0);
    acc("stat_post_rst", 32'h1000_0100, 32'h0, 4'h0, 32'h0000_0300);
    rd(32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
